// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR second-order loop filter.
package cdr_pkg;

    typedef logic signed [1:0] vote_t;

    // Bits needed for a counter running 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed for a signed sum spanning -n..+n.
    function automatic int sum_w(input int n);
        return $clog2(n + 1) + 1;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint s;
        longint hi;
        longint lo;
        s  = a + b;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        return s;
    endfunction

endpackage

// File: rtl/cdr_lock_detect.sv
// Lock detector: counts quiet vote windows and asserts locked after enough in a row.
module cdr_lock_detect
    import cdr_pkg::*;
#(
    parameter int LOCK_WIN = 32,
    parameter int LOCK_THR = 4,
    parameter int LOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] vote,
    input  logic       strobe,
    input  logic       freeze,
    output logic       locked
);

    localparam int WCNT_W = cnt_w(LOCK_WIN);
    localparam int NSUM_W = sum_w(LOCK_WIN);
    localparam int QCNT_W = cnt_w(LOCK_CNT + 1);

    vote_t                    v;
    logic [WCNT_W-1:0]        win_cnt;
    logic signed [NSUM_W-1:0] net_sum;
    logic signed [NSUM_W-1:0] net_now;
    logic signed [NSUM_W-1:0] abs_net;
    logic [QCNT_W-1:0]        q_cnt;
    logic                     win_end;
    logic                     quiet;

    always_comb begin
        v       = vote_t'(vote);
        net_now = net_sum + NSUM_W'(v);
        abs_net = (net_now < 0) ? -net_now : net_now;
        quiet   = (int'(abs_net) <= LOCK_THR);
        win_end = (win_cnt == WCNT_W'(LOCK_WIN - 1));
    end

    // Frozen votes are ignored entirely so the window stays aligned on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            net_sum <= '0;
            q_cnt   <= '0;
        end else if (strobe && !freeze) begin
            if (win_end) begin
                win_cnt <= '0;
                net_sum <= '0;
                if (!quiet)
                    q_cnt <= '0;
                else if (q_cnt != QCNT_W'(LOCK_CNT))
                    q_cnt <= q_cnt + 1'b1;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                net_sum <= net_now;
            end
        end
    end

    assign locked = (q_cnt == QCNT_W'(LOCK_CNT));

endmodule

// File: rtl/cdr_dlf_2nd_order.sv
// Second-order bang-bang CDR loop filter: vote decimation, proportional + integral paths,
// wrapping phase accumulator driving the PI code, freeze and lock detect.
module cdr_dlf_2nd_order
    import cdr_pkg::*;
#(
    parameter int CODE_W   = 11,
    parameter int FRAC_W   = 6,
    parameter int FREQ_W   = 12,
    parameter int DECIM    = 4,
    parameter int KP       = 16,
    parameter int KI       = 1,
    parameter int LOCK_WIN = 32,
    parameter int LOCK_THR = 4,
    parameter int LOCK_CNT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up,
    input  logic              dn,
    input  logic              freeze,
    output logic [CODE_W-1:0] code,
    output logic [FREQ_W-1:0] freq,
    output logic              vld,
    output logic              locked
);

    localparam int PH_W   = CODE_W + FRAC_W;
    localparam int DCNT_W = cnt_w(DECIM);
    localparam int DSUM_W = sum_w(DECIM);

    logic [DCNT_W-1:0]        dec_cnt;
    logic signed [DSUM_W-1:0] dec_sum;
    logic signed [DSUM_W-1:0] sum_now;
    logic signed [1:0]        d_smp;
    vote_t                    vote;
    logic                     strobe;
    logic [PH_W-1:0]          ph;
    logic [PH_W-1:0]          ph_nxt;
    logic signed [FREQ_W-1:0] freq_q;
    logic signed [FREQ_W-1:0] freq_nxt;
    logic signed [PH_W:0]     kp_term;
    logic signed [PH_W:0]     fq_term;
    logic                     vld_q;

    always_comb begin
        d_smp = 2'sd0;
        if (up && !dn)
            d_smp = 2'sd1;
        else if (dn && !up)
            d_smp = -2'sd1;
        sum_now = dec_sum + DSUM_W'(d_smp);
        strobe  = (dec_cnt == DCNT_W'(DECIM - 1));
        vote    = 2'sd0;
        if (sum_now > 0)
            vote = 2'sd1;
        else if (sum_now < 0)
            vote = -2'sd1;
    end

    // Phase step uses the pre-update frequency: one-vote integral delay.
    always_comb begin
        kp_term = '0;
        if (vote == 2'sd1)
            kp_term = (PH_W + 1)'(KP);
        else if (vote == -2'sd1)
            kp_term = -((PH_W + 1)'(KP));
        fq_term  = (PH_W + 1)'(freq_q);
        ph_nxt   = PH_W'($signed({1'b0, ph}) + kp_term + fq_term);
        freq_nxt = FREQ_W'(sat_add(longint'(freq_q), longint'(vote) * longint'(KI), FREQ_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
            dec_sum <= '0;
            ph      <= '0;
            freq_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= strobe;
            if (strobe) begin
                dec_cnt <= '0;
                dec_sum <= '0;
                if (!freeze) begin
                    freq_q <= freq_nxt;
                    ph     <= ph_nxt;
                end
            end else begin
                dec_cnt <= dec_cnt + 1'b1;
                dec_sum <= sum_now;
            end
        end
    end

    cdr_lock_detect #(
        .LOCK_WIN (LOCK_WIN),
        .LOCK_THR (LOCK_THR),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock (
        .clk    (clk),
        .rst_n  (rst_n),
        .vote   (vote),
        .strobe (strobe),
        .freeze (freeze),
        .locked (locked)
    );

    assign code = ph[PH_W-1:FRAC_W];
    assign freq = freq_q;
    assign vld  = vld_q;

endmodule

// File: tb/tb_cdr_dlf_2nd_order.sv
// Scoreboard bench for cdr_dlf_2nd_order with default parameters.
module tb_cdr_dlf_2nd_order;

    localparam int CODE_W   = 11;
    localparam int FRAC_W   = 6;
    localparam int FREQ_W   = 12;
    localparam int DECIM    = 4;
    localparam int KP       = 16;
    localparam int KI       = 1;
    localparam int LOCK_WIN = 32;
    localparam int LOCK_THR = 4;
    localparam int LOCK_CNT = 3;
    localparam int PH_W     = CODE_W + FRAC_W;
    localparam longint PH_MOD = longint'(1) << PH_W;
    localparam longint F_HI   = (longint'(1) << (FREQ_W - 1)) - 1;
    localparam longint F_LO   = -(longint'(1) << (FREQ_W - 1));

    logic              clk = 1'b0;
    logic              rst_n;
    logic              up;
    logic              dn;
    logic              freeze;
    logic [CODE_W-1:0] code;
    logic [FREQ_W-1:0] freq;
    logic              vld;
    logic              locked;

    always #5 clk = ~clk;

    cdr_dlf_2nd_order #(
        .CODE_W (CODE_W), .FRAC_W (FRAC_W), .FREQ_W (FREQ_W), .DECIM (DECIM),
        .KP (KP), .KI (KI), .LOCK_WIN (LOCK_WIN), .LOCK_THR (LOCK_THR), .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .up     (up),
        .dn     (dn),
        .freeze (freeze),
        .code   (code),
        .freq   (freq),
        .vld    (vld),
        .locked (locked)
    );

    typedef struct {
        longint code;
        longint freq;
        bit     locked;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;
    int     m_cnt, m_sum, m_win, m_net, m_q;
    longint m_freq, m_ph;
    longint held_code, held_freq;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_sum = 0; m_win = 0; m_net = 0; m_q = 0;
        m_freq = 0; m_ph = 0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit f);
        int     dd;
        int     v;
        longint nf;
        exp_t   e;
        dd = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
        m_sum += dd;
        if (m_cnt == DECIM - 1) begin
            v = (m_sum > 0) ? 1 : ((m_sum < 0) ? -1 : 0);
            m_sum = 0;
            m_cnt = 0;
            if (!f) begin
                nf = m_freq + v * KI;
                if (nf > F_HI) nf = F_HI;
                if (nf < F_LO) nf = F_LO;
                m_ph = ((m_ph + v * KP + m_freq) % PH_MOD + PH_MOD) % PH_MOD;
                m_freq = nf;
                m_net += v;
                m_win++;
                if (m_win == LOCK_WIN) begin
                    if ((m_net <= LOCK_THR) && (m_net >= -LOCK_THR))
                        m_q = (m_q < LOCK_CNT) ? m_q + 1 : LOCK_CNT;
                    else
                        m_q = 0;
                    m_win = 0;
                    m_net = 0;
                end
            end
            e.code   = m_ph >> FRAC_W;
            e.freq   = m_freq;
            e.locked = (m_q == LOCK_CNT);
            sb.push_back(e);
        end else begin
            m_cnt++;
        end
    endtask

    task automatic step(input bit u, input bit d, input bit f);
        exp_t e;
        up = u; dn = d; freeze = f;
        model_step(u, d, f);
        @(posedge clk);
        #1;
        check_val("vld", longint'(vld), longint'(sb.size() > 0));
        if (vld && sb.size() > 0) begin
            e = sb.pop_front();
            check_val("code", longint'(code), e.code);
            check_val("freq", longint'($signed(freq)), e.freq);
            check_val("locked", longint'(locked), longint'(e.locked));
        end
    endtask

    task automatic run_votes(input int n, input bit u, input bit d, input bit f);
        for (int i = 0; i < n * DECIM; i++)
            step(u, d, f);
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_code", longint'(code), 0);
        check_val("rst_freq", longint'($signed(freq)), 0);
        check_val("rst_locked", longint'(locked), 0);
        check_val("rst_vld", longint'(vld), 0);
        model_clear();
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; up = 1'b0; dn = 1'b0; freeze = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_val("init_code", longint'(code), 0);
        check_val("init_freq", longint'($signed(freq)), 0);
        check_val("init_vld", longint'(vld), 0);
        check_val("init_locked", longint'(locked), 0);
        rst_n = 1'b1;

        // constant up: freq ramps 1,2,3 and phase eventually wraps
        run_votes(3, 1, 0, 0);
        check_val("freq_after_3", longint'($signed(freq)), 3);
        run_votes(600, 1, 0, 0);

        // reset in the middle of a decimation block
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        mid_reset();

        // invalid samples and intra-block cancellation give zero votes; lock after 3 windows
        run_votes(LOCK_WIN * LOCK_CNT - 8, 1, 1, 0);
        for (int i = 0; i < 8 * DECIM; i++) step(i[0], !i[0], 0);
        check_val("locked_quiet", longint'(locked), 1);
        check_val("quiet_code", longint'(code), 0);

        // one noisy window (net +10) drops lock, three quiet windows restore it
        run_votes(21, 1, 0, 0);
        run_votes(11, 0, 1, 0);
        check_val("unlock_noisy", longint'(locked), 0);
        run_votes(LOCK_WIN * (LOCK_CNT - 1), 1, 1, 0);
        check_val("still_unlocked", longint'(locked), 0);
        run_votes(LOCK_WIN, 1, 1, 0);
        check_val("relock", longint'(locked), 1);

        // freeze during constant dn
        run_votes(20, 0, 1, 0);
        held_code = longint'(code);
        held_freq = longint'($signed(freq));
        run_votes(20, 0, 1, 1);
        check_val("frz_code", longint'(code), held_code);
        check_val("frz_freq", longint'($signed(freq)), held_freq);
        run_votes(20, 0, 1, 0);

        // integrator saturation both ways
        mid_reset();
        run_votes(int'(F_HI) + 60, 1, 0, 0);
        check_val("freq_sat_hi", longint'($signed(freq)), F_HI);
        run_votes(2 * int'(F_HI) + 120, 0, 1, 0);
        check_val("freq_sat_lo", longint'($signed(freq)), F_LO);

        // random traffic with occasional freeze
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

        check_val("sb_drain", longint'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
